uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 140 ++++++++++++++
 tb/tb_uart_tx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_tx
// Description : 8-bit asynchronous serial transmitter. Start bit, 8 data bits
//               LSB first, optional even/odd parity bit, then 1 or 2 stop
//               bits. Every bit lasts OVERSAMPLE clk cycles. A frame is
//               accepted only from IDLE while cts is high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int OVERSAMPLE = 16,   // clk cycles per bit, 2..256
    parameter int PARITY_EN  = 0,    // 1 inserts a parity bit before the stop bit(s)
    parameter int PARITY_ODD = 0,    // 0 even parity, 1 odd parity
    parameter int STOP_BITS  = 1     // 1 or 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] data,
    input  logic       cts,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    // Bit-period counter runs 0..OVERSAMPLE-1; 256 still fits in 8 bits.
    localparam int                  c_cnt_w    = $clog2(OVERSAMPLE);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(OVERSAMPLE - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [2:0]          c_stop_last = 3'(STOP_BITS - 1);
    localparam logic                c_par_odd  = (PARITY_ODD != 0);
    localparam logic                c_par_en   = (PARITY_EN != 0);

    // Frame sequencer states.
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit;     // data bit index, reused as stop bit index
    logic [7:0]         r_shift;
    logic               r_par;     // parity of the accepted byte, fixed at acceptance
    logic               r_txd;
    logic               r_busy;
    logic               r_done;
    logic               w_bit_end;

    assign w_bit_end = (r_cnt == c_cnt_last);

    assign txd     = r_txd;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

    // Frame sequencer: every output is registered; reset overrides all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Bit timer advances in every non-idle state and wraps per bit.
            if (r_state != c_st_idle) begin
                r_cnt <= w_bit_end ? '0 : r_cnt + c_cnt_one;
            end
            case (r_state)
                c_st_idle: begin
                    if (tx_start && cts) begin
                        r_shift <= data;
                        r_par   <= (^data) ^ c_par_odd;
                        r_state <= c_st_start;
                        r_txd   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_bit   <= 3'd0;
                    end
                end
                c_st_start: begin
                    if (w_bit_end) begin
                        r_state <= c_st_data;
                        r_txd   <= r_shift[0];
                    end
                end
                c_st_data: begin
                    if (w_bit_end) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_bit <= 3'd0;
                            if (c_par_en) begin
                                r_state <= c_st_parity;
                                r_txd   <= r_par;
                            end else begin
                                r_state <= c_st_stop;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_txd <= r_shift[1];
                        end
                    end
                end
                c_st_parity: begin
                    if (w_bit_end) begin
                        r_state <= c_st_stop;
                        r_txd   <= 1'b1;
                        r_bit   <= 3'd0;
                    end
                end
                c_st_stop: begin
                    if (w_bit_end) begin
                        if (r_bit == c_stop_last) begin
                            r_state <= c_st_idle;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_bit   <= 3'd0;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx
// Description : Scoreboard bench for uart_tx. Three parameter sets run side by
//               side; a driver predicts accepted frames into a queue and a
//               line monitor decodes txd and compares against that queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after posedge number N (and #1), cyc == N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    bit fin [3];

    typedef struct {
        logic [7:0] b;
        int         acc;
    } exp_t;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int OVS   = (g == 2) ? 2 : 16;
        localparam int PEN   = (g == 0) ? 0 : 1;
        localparam int PODD  = (g == 1) ? 1 : 0;
        localparam int SB    = (g == 1) ? 2 : 1;
        localparam int NB    = 1 + 8 + PEN + SB;
        localparam int FRAME = OVS * NB;

        logic       rst, tx_start, cts, txd, tx_busy, tx_done;
        logic [7:0] data;

        uart_tx #(
            .OVERSAMPLE (OVS),
            .PARITY_EN  (PEN),
            .PARITY_ODD (PODD),
            .STOP_BITS  (SB)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .tx_start (tx_start),
            .data     (data),
            .cts      (cts),
            .txd      (txd),
            .tx_busy  (tx_busy),
            .tx_done  (tx_done)
        );

        exp_t q[$];
        int   next_free = 0;   // first edge on which a new frame may be accepted

        // Drive one cycle of inputs and update the acceptance model.
        task automatic step(input bit r, input bit s, input bit c, input logic [7:0] d);
            rst = r; tx_start = s; cts = c; data = d;
            @(posedge clk); #1;
            if (r) next_free = cyc + 1;
            else if (s && c && cyc >= next_free) begin
                q.push_back('{d, cyc});
                next_free = cyc + FRAME + 1;
            end
        endtask

        task automatic idle_until_free();
            while (cyc + 1 < next_free) step(1'b0, 1'b0, 1'b1, 8'h00);
            step(1'b0, 1'b0, 1'b1, 8'h00);
        endtask

        initial begin
            // Reset with tx_start asserted must not start a frame.
            repeat (3) step(1'b1, 1'b1, 1'b1, 8'hFF);
            repeat (2) step(1'b0, 1'b0, 1'b1, 8'h00);
            // Single pulses.
            step(1'b0, 1'b1, 1'b1, 8'hA5); idle_until_free();
            step(1'b0, 1'b1, 1'b1, 8'h07); idle_until_free();
            // cts low blocks, rising cts accepts, mid-frame noise is ignored.
            repeat (50) step(1'b0, 1'b1, 1'b0, 8'h5A);
            step(1'b0, 1'b1, 1'b1, 8'h5A);
            repeat (OVS * 3) step(1'b0, cyc[0], 1'b0, 8'($urandom));
            idle_until_free();
            // tx_start held high across two back-to-back frames.
            step(1'b0, 1'b1, 1'b1, 8'h3C);
            while (cyc + 1 < next_free) step(1'b0, 1'b1, 1'b1, 8'hC3);
            step(1'b0, 1'b1, 1'b1, 8'hC3);
            step(1'b0, 1'b0, 1'b1, 8'h00);
            idle_until_free();
            // Reset in the middle of data bit 3, then a clean frame.
            step(1'b0, 1'b1, 1'b1, 8'hE7);
            repeat (OVS * 4 + OVS / 2 - 1) step(1'b0, 1'b0, 1'b1, 8'h00);
            step(1'b1, 1'b0, 1'b1, 8'h00);
            step(1'b0, 1'b0, 1'b1, 8'h00);
            step(1'b0, 1'b1, 1'b1, 8'h55);
            step(1'b0, 1'b0, 1'b1, 8'h00);
            idle_until_free();
            // Random traffic.
            repeat (4000) step($urandom_range(0, 999) == 0, $urandom_range(0, 3) == 0,
                               $urandom_range(0, 7) != 0, 8'($urandom));
            idle_until_free();
            repeat (3) step(1'b0, 1'b0, 1'b1, 8'h00);
            check(q.size() == 0, $sformatf("cfg%0d queue drained", g), q.size(), 0);
            fin[g] = 1'b1;
        end

        // Line monitor: decode txd, time each frame, compare with the queue.
        bit          active  = 1'b0;
        bit          rst_seen = 1'b0;
        int          start_cyc;
        bit          glitch;
        logic [11:0] gotv;

        always @(negedge clk) begin : mon
            int          k, b, ph;
            logic [11:0] expv;
            exp_t        e;
            if (rst_seen) begin
                check(txd && !tx_busy && !tx_done, $sformatf("cfg%0d reset state", g),
                      int'({txd, tx_busy, tx_done}), 4);
                if (active && q.size() > 0) void'(q.pop_front());
                active = 1'b0;
            end else if (active) begin
                k = cyc - start_cyc;
                if (k < FRAME) begin
                    check(tx_busy && !tx_done, $sformatf("cfg%0d busy in frame", g),
                          int'({tx_busy, tx_done}), 2);
                    b  = k / OVS;
                    ph = k % OVS;
                    if (ph == 0) gotv[b] = txd;
                    else if (txd != gotv[b]) glitch = 1'b1;
                end else begin
                    check(tx_done && !tx_busy, $sformatf("cfg%0d done at frame end", g),
                          int'({tx_busy, tx_done}), 1);
                    check(!glitch, $sformatf("cfg%0d bit stable", g), glitch, 0);
                    if (q.size() == 0) begin
                        check(1'b0, $sformatf("cfg%0d frame with empty queue", g), gotv, -1);
                    end else begin
                        e = q.pop_front();
                        expv = '1;
                        expv[0] = 1'b0;
                        expv[8:1] = e.b;
                        if (PEN != 0) expv[9] = (^e.b) ^ (PODD != 0);
                        check(gotv[8:1] == e.b, $sformatf("cfg%0d data byte", g), gotv[8:1], e.b);
                        check(gotv == expv, $sformatf("cfg%0d frame bits", g), gotv, expv);
                    end
                    active = 1'b0;
                end
            end else begin
                check(!tx_done, $sformatf("cfg%0d stray done", g), tx_done, 0);
                if (tx_busy) begin
                    active    = 1'b1;
                    start_cyc = cyc;
                    glitch    = 1'b0;
                    gotv      = '1;
                    gotv[0]   = txd;
                    if (q.size() == 0)
                        check(1'b0, $sformatf("cfg%0d unexpected frame", g), cyc, -1);
                    else
                        check(q[0].acc == cyc, $sformatf("cfg%0d accept edge", g), cyc, q[0].acc);
                end else begin
                    check(txd == 1'b1, $sformatf("cfg%0d idle line", g), txd, 1);
                end
            end
            rst_seen = rst;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && !(fin[0] && fin[1] && fin[2]); i++) @(posedge clk);
        check(fin[0] && fin[1] && fin[2], "completion within cycle budget",
              int'({fin[2], fin[1], fin[0]}), 7);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
